calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_key_decode.sv | 20 ++
 rtl/calc_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: key codes, state encoding, operator and memory command codes for the calculator sequencer
package calc_pkg;
    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQU = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [2:0] {
        ST_OP1  = 3'b000,
        ST_OP2  = 3'b001,
        ST_CALC = 3'b010,
        ST_SHOW = 3'b011,
        ST_LOAD = 3'b100,
        ST_ERR  = 3'b101
    } state_t;

    typedef enum logic [1:0] {
        OPR_ADD = 2'b00,
        OPR_SUB = 2'b01,
        OPR_MUL = 2'b10,
        OPR_DIV = 2'b11
    } opr_t;

    localparam logic [1:0] SAVE_NONE = 2'b00;
    localparam logic [1:0] SAVE_D1   = 2'b01;
    localparam logic [1:0] SAVE_OPR  = 2'b10;
    localparam logic [1:0] SAVE_D2   = 2'b11;
endpackage

// File: rtl/calc_key_decode.sv
// calc_key_decode: classifies a key code as digit, operator, equals or clear
module calc_key_decode
    import calc_pkg::*;
(
    input  logic [3:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_equ,
    output logic       is_clr,
    output logic [3:0] digit,
    output logic [1:0] op
);
    assign is_digit = key_code < KEY_ADD;
    assign is_op    = key_code >= KEY_ADD && key_code <= KEY_DIV;
    assign is_equ   = key_code == KEY_EQU;
    assign is_clr   = key_code == KEY_CLR;
    assign digit    = key_code;
    // 10..13 map to 00..11: low two bits offset by 2 modulo 4
    assign op       = key_code[1:0] ^ 2'b10;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven FSM issuing registered digit/operator/equals/clear commands to calculator memory
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int EQU_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic       alu_done,
    output logic [3:0] num,
    output logic [1:0] operator,
    output logic [1:0] save_enable,
    output logic       op_enable,
    output logic       equ_enable,
    output logic       clear_enable,
    output logic [2:0] state,
    output logic       error
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(EQU_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(EQU_TIMEOUT - 1);

    state_t        st;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [3:0]    pend;
    logic          is_digit, is_op, is_equ, is_clr, acc;
    logic [3:0]    digit;
    logic [1:0]    op;

    calc_key_decode u_dec (
        .key_code(key_code),
        .is_digit(is_digit),
        .is_op(is_op),
        .is_equ(is_equ),
        .is_clr(is_clr),
        .digit(digit),
        .op(op)
    );

    assign key_ready = st != ST_CALC && st != ST_LOAD;
    assign acc       = key_valid && key_ready;
    assign state     = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= ST_OP1;
            cnt          <= '0;
            tmo          <= '0;
            pend         <= '0;
            num          <= '0;
            operator     <= OPR_ADD;
            save_enable  <= SAVE_NONE;
            op_enable    <= 1'b0;
            equ_enable   <= 1'b0;
            clear_enable <= 1'b0;
            error        <= 1'b0;
        end else begin
            save_enable  <= SAVE_NONE;
            op_enable    <= 1'b0;
            equ_enable   <= 1'b0;
            clear_enable <= 1'b0;
            if (acc && is_clr && st != ST_CALC && st != ST_LOAD) begin
                clear_enable <= 1'b1;
                cnt          <= '0;
                error        <= 1'b0;
                st           <= ST_OP1;
            end else begin
                case (st)
                    ST_OP1, ST_OP2: begin
                        if (acc && is_digit && cnt < CNT_MAX) begin
                            save_enable <= st == ST_OP1 ? SAVE_D1 : SAVE_D2;
                            num         <= digit;
                            cnt         <= cnt + 1'b1;
                        end else if (acc && is_op && st == ST_OP1 && cnt != '0) begin
                            save_enable <= SAVE_OPR;
                            op_enable   <= 1'b1;
                            operator    <= op;
                            cnt         <= '0;
                            st          <= ST_OP2;
                        end else if (acc && is_op && st == ST_OP2 && cnt == '0) begin
                            save_enable <= SAVE_OPR;
                            operator    <= op;
                        end else if (acc && is_equ && st == ST_OP2 && cnt != '0) begin
                            equ_enable <= 1'b1;
                            tmo        <= '0;
                            st         <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        // a result arriving on the final timeout cycle still counts
                        if (alu_done) st <= ST_SHOW;
                        else if (tmo == TMO_LAST) begin
                            st    <= ST_ERR;
                            error <= 1'b1;
                        end else tmo <= tmo + 1'b1;
                    end
                    ST_SHOW: begin
                        if (acc && is_digit) begin
                            clear_enable <= 1'b1;
                            pend         <= digit;
                            st           <= ST_LOAD;
                        end else if (acc && is_op) begin
                            save_enable <= SAVE_OPR;
                            op_enable   <= 1'b1;
                            operator    <= op;
                            cnt         <= '0;
                            st          <= ST_OP2;
                        end
                    end
                    ST_LOAD: begin
                        save_enable <= SAVE_D1;
                        num         <= pend;
                        cnt         <= CW'(1);
                        st          <= ST_OP1;
                    end
                    ST_ERR: ;
                    default: st <= ST_OP1;
                endcase
            end
        end
    end
endmodule
